// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 scancode to keyboard-matrix translator.
// Parses F0/E0/E1 prefixes, keeps the held-key vector, reports key changes
// and serves an active-low scanned column readout to the CPU keyboard port.
module ps2_key_matrix #(
   parameter int          ROWS        = 8,
   parameter int          COLS        = 5,
   parameter bit          EXT_ENABLE  = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 2**20,
   localparam int         NKEYS       = ROWS * COLS,
   localparam int         IDXW        = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_valid,
   input  logic [7:0]       data,
   input  logic [ROWS-1:0]  row_sel,
   output logic [COLS-1:0]  col_n,
   output logic [NKEYS-1:0] kb_state,
   output logic             any_key,
   output logic             key_evt,
   output logic             key_evt_make,
   output logic [IDXW-1:0]  key_evt_idx
);

   localparam int TOW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {
      IDLE,
      BRK,
      EXT,
      EXT_BRK,
      SKIP
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       skip_q, skip_d;
   logic [TOW-1:0]   idle_cnt_q, idle_cnt_d;
   logic [NKEYS-1:0] kb_state_q, kb_state_d;
   logic             any_key_q, any_key_d;
   logic             key_evt_q, key_evt_d;
   logic             key_evt_make_q, key_evt_make_d;
   logic [IDXW-1:0]  key_evt_idx_q, key_evt_idx_d;
   logic [COLS-1:0]  col_n_q, col_n_d;

   logic             timeoutHit;
   logic             doLookup;
   logic             lookupMake;
   logic             lookupExt;
   logic [6:0]       entry;
   int               keyIdx;

   // Plain set-2 table: {hit, row, col}. Codes absent here are unmapped.
   function automatic logic [6:0] lookupCode(input logic [7:0] code);
      case (code)
         8'h16: lookupCode = {1'b1, 3'd0, 3'd0};
         8'h1E: lookupCode = {1'b1, 3'd0, 3'd1};
         8'h26: lookupCode = {1'b1, 3'd0, 3'd2};
         8'h25: lookupCode = {1'b1, 3'd0, 3'd3};
         8'h2E: lookupCode = {1'b1, 3'd0, 3'd4};
         8'h15: lookupCode = {1'b1, 3'd1, 3'd0};
         8'h1D: lookupCode = {1'b1, 3'd1, 3'd1};
         8'h24: lookupCode = {1'b1, 3'd1, 3'd2};
         8'h2D: lookupCode = {1'b1, 3'd1, 3'd3};
         8'h2C: lookupCode = {1'b1, 3'd1, 3'd4};
         8'h1C: lookupCode = {1'b1, 3'd2, 3'd0};
         8'h1B: lookupCode = {1'b1, 3'd2, 3'd1};
         8'h23: lookupCode = {1'b1, 3'd2, 3'd2};
         8'h2B: lookupCode = {1'b1, 3'd2, 3'd3};
         8'h34: lookupCode = {1'b1, 3'd2, 3'd4};
         8'h12: lookupCode = {1'b1, 3'd3, 3'd0};
         8'h1A: lookupCode = {1'b1, 3'd3, 3'd1};
         8'h22: lookupCode = {1'b1, 3'd3, 3'd2};
         8'h21: lookupCode = {1'b1, 3'd3, 3'd3};
         8'h2A: lookupCode = {1'b1, 3'd3, 3'd4};
         8'h29: lookupCode = {1'b1, 3'd4, 3'd0};
         8'h41: lookupCode = {1'b1, 3'd4, 3'd1};
         8'h3A: lookupCode = {1'b1, 3'd4, 3'd2};
         8'h31: lookupCode = {1'b1, 3'd4, 3'd3};
         8'h32: lookupCode = {1'b1, 3'd4, 3'd4};
         8'h5A: lookupCode = {1'b1, 3'd5, 3'd0};
         8'h4B: lookupCode = {1'b1, 3'd5, 3'd1};
         8'h42: lookupCode = {1'b1, 3'd5, 3'd2};
         8'h3B: lookupCode = {1'b1, 3'd5, 3'd3};
         8'h33: lookupCode = {1'b1, 3'd5, 3'd4};
         8'h4D: lookupCode = {1'b1, 3'd6, 3'd0};
         8'h44: lookupCode = {1'b1, 3'd6, 3'd1};
         8'h43: lookupCode = {1'b1, 3'd6, 3'd2};
         8'h3C: lookupCode = {1'b1, 3'd6, 3'd3};
         8'h35: lookupCode = {1'b1, 3'd6, 3'd4};
         8'h45: lookupCode = {1'b1, 3'd7, 3'd0};
         8'h46: lookupCode = {1'b1, 3'd7, 3'd1};
         8'h3E: lookupCode = {1'b1, 3'd7, 3'd2};
         8'h3D: lookupCode = {1'b1, 3'd7, 3'd3};
         8'h36: lookupCode = {1'b1, 3'd7, 3'd4};
         default: lookupCode = 7'd0;
      endcase
   endfunction

   // A pending prefix is abandoned after TIMEOUT_CYC quiet clocks; 0 disables it.
   assign timeoutHit = (TIMEOUT_CYC != 0) && (idle_cnt_q == TOW'(TIMEOUT_CYC - 1));

   // Prefix parser, key-vector update and change-event generation.
   always_comb begin
      state_d        = state_q;
      skip_d         = skip_q;
      kb_state_d     = kb_state_q;
      key_evt_d      = 1'b0;
      key_evt_make_d = key_evt_make_q;
      key_evt_idx_d  = key_evt_idx_q;
      doLookup       = 1'b0;
      lookupMake     = 1'b0;
      lookupExt      = 1'b0;
      entry          = 7'd0;
      keyIdx         = 0;

      if (data_valid) begin
         case (state_q)
            IDLE: begin
               if (data == 8'hF0) begin
                  state_d = BRK;
               end else if (data == 8'hE0) begin
                  state_d = EXT;
               end else if (data == 8'hE1) begin
                  state_d = SKIP;
                  skip_d  = 3'd7;
               end else if (data == 8'hAA || data == 8'h00 || data == 8'hFF || data == 8'hFC) begin
                  kb_state_d = '0;
               end else begin
                  doLookup   = 1'b1;
                  lookupMake = 1'b1;
               end
            end
            BRK: begin
               if (data != 8'hF0) begin
                  state_d  = IDLE;
                  doLookup = 1'b1;
               end
            end
            EXT: begin
               if (data == 8'hF0) begin
                  state_d = EXT_BRK;
               end else begin
                  state_d    = IDLE;
                  doLookup   = 1'b1;
                  lookupMake = 1'b1;
                  lookupExt  = 1'b1;
               end
            end
            EXT_BRK: begin
               state_d   = IDLE;
               doLookup  = 1'b1;
               lookupExt = 1'b1;
            end
            SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q <= 3'd1) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (timeoutHit) begin
         state_d = IDLE;
      end

      if (doLookup) begin
         if (lookupExt) begin
            entry = (EXT_ENABLE && data == 8'h5A) ? {1'b1, 3'd5, 3'd0} : 7'd0;
         end else begin
            entry = lookupCode(data);
         end
         if (entry[6] && (int'(entry[5:3]) < ROWS) && (int'(entry[2:0]) < COLS)) begin
            keyIdx = int'(entry[5:3]) * COLS + int'(entry[2:0]);
            if (kb_state_q[keyIdx] != lookupMake) begin
               kb_state_d[keyIdx] = lookupMake;
               key_evt_d          = 1'b1;
               key_evt_make_d     = lookupMake;
               key_evt_idx_d      = IDXW'(keyIdx);
            end
         end
      end
   end

   // Quiet-clock counter only runs while a prefix is pending.
   always_comb begin
      idle_cnt_d = idle_cnt_q + TOW'(1);
      if (TIMEOUT_CYC == 0 || state_q == IDLE || data_valid || timeoutHit) begin
         idle_cnt_d = '0;
      end
   end

   // any_key tracks the vector being registered so it lands on the same edge.
   assign any_key_d = |kb_state_d;

   // Scanned readout: a column goes low if any driven row holds a key in it.
   always_comb begin
      col_n_d = '1;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            if (kb_state_q[r*COLS + c] && !row_sel[r]) begin
               col_n_d[c] = 1'b0;
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         skip_q         <= 3'd0;
         idle_cnt_q     <= '0;
         kb_state_q     <= '0;
         any_key_q      <= 1'b0;
         key_evt_q      <= 1'b0;
         key_evt_make_q <= 1'b0;
         key_evt_idx_q  <= '0;
         col_n_q        <= '1;
      end else begin
         state_q        <= state_d;
         skip_q         <= skip_d;
         idle_cnt_q     <= idle_cnt_d;
         kb_state_q     <= kb_state_d;
         any_key_q      <= any_key_d;
         key_evt_q      <= key_evt_d;
         key_evt_make_q <= key_evt_make_d;
         key_evt_idx_q  <= key_evt_idx_d;
         col_n_q        <= col_n_d;
      end
   end

   assign col_n        = col_n_q;
   assign kb_state     = kb_state_q;
   assign any_key      = any_key_q;
   assign key_evt      = key_evt_q;
   assign key_evt_make = key_evt_make_q;
   assign key_evt_idx  = key_evt_idx_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: one instance with keypad Enter mapped and a
// short timeout, and a second with extended codes disabled sharing the same stimulus.
module tb_ps2_key_matrix;

   localparam int TOUT = 16;

   logic        clk;
   logic        rst_n;
   logic        data_valid;
   logic [7:0]  data;
   logic [7:0]  row_sel;

   logic [4:0]  col_n, col_n0;
   logic [39:0] kb_state, kb_state0;
   logic        any_key, any_key0;
   logic        key_evt, key_evt0;
   logic        key_evt_make, key_evt_make0;
   logic [5:0]  key_evt_idx, key_evt_idx0;

   int checkCount = 0;
   int errorCount = 0;
   int evtCount   = 0;
   int evtBase;

   ps2_key_matrix #(.ROWS(8), .COLS(5), .EXT_ENABLE(1'b1), .TIMEOUT_CYC(TOUT)) dut (
      .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data(data), .row_sel(row_sel),
      .col_n(col_n), .kb_state(kb_state), .any_key(any_key), .key_evt(key_evt),
      .key_evt_make(key_evt_make), .key_evt_idx(key_evt_idx)
   );

   ps2_key_matrix #(.ROWS(8), .COLS(5), .EXT_ENABLE(1'b0), .TIMEOUT_CYC(TOUT)) dutNoExt (
      .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data(data), .row_sel(row_sel),
      .col_n(col_n0), .kb_state(kb_state0), .any_key(any_key0), .key_evt(key_evt0),
      .key_evt_make(key_evt_make0), .key_evt_idx(key_evt_idx0)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every key_evt pulse of the main instance, sampled just after the edge.
   always @(posedge clk) begin
      #1;
      if (key_evt) evtCount++;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One byte strobe; returns at the falling edge after the sampling edge.
   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      data_valid = 1'b1;
      data       = b;
      @(negedge clk);
      data_valid = 1'b0;
      data       = 8'h00;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      data_valid = 1'b0;
      data       = 8'h00;
      row_sel    = 8'hFF;
      idleCycles(3);
      checkOutput("reset_kb", kb_state, 64'h0);
      checkOutput("reset_any", any_key, 64'h0);
      checkOutput("reset_col", col_n, 64'h1F);
      checkOutput("reset_evt", {key_evt, key_evt_make, key_evt_idx}, 64'h0);
      rst_n = 1'b1;
      idleCycles(2);

      // 1) make and break of A
      applyStimulus(8'h1C);
      checkOutput("a_make_kb", kb_state, 64'h400);
      checkOutput("a_make_evt", {key_evt, key_evt_make, key_evt_idx}, {56'h0, 1'b1, 1'b1, 6'd10});
      checkOutput("a_make_any", any_key, 64'h1);
      idleCycles(1);
      checkOutput("evt_one_cycle", key_evt, 64'h0);
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);
      checkOutput("a_brk_kb", kb_state, 64'h0);
      checkOutput("a_brk_evt", {key_evt, key_evt_make, key_evt_idx}, {56'h0, 1'b1, 1'b0, 6'd10});
      checkOutput("a_brk_any", any_key, 64'h0);

      // 2) typematic repeat and break of an unheld key
      evtBase = evtCount;
      applyStimulus(8'h1C);
      applyStimulus(8'h1C);
      applyStimulus(8'h1C);
      checkOutput("typematic_evts", evtCount - evtBase, 64'd1);
      checkOutput("typematic_kb", kb_state, 64'h400);
      evtBase = evtCount;
      applyStimulus(8'hF0);
      applyStimulus(8'h2E);
      checkOutput("unheld_brk_evts", evtCount - evtBase, 64'd0);
      checkOutput("unheld_brk_kb", kb_state, 64'h400);
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);
      checkOutput("cleanup_kb", kb_state, 64'h0);

      // 3) extended codes
      applyStimulus(8'hE0);
      applyStimulus(8'h5A);
      checkOutput("kpenter_make_kb", kb_state, 64'h1 << 25);
      checkOutput("kpenter_make_evt", {key_evt, key_evt_make, key_evt_idx}, {56'h0, 1'b1, 1'b1, 6'd25});
      checkOutput("noext_kpenter_kb", kb_state0, 64'h0);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h5A);
      checkOutput("kpenter_brk_kb", kb_state, 64'h0);
      evtBase = evtCount;
      applyStimulus(8'hE0);
      applyStimulus(8'h75);
      applyStimulus(8'hE0);
      applyStimulus(8'h12);
      checkOutput("ext_ignored_kb", kb_state, 64'h0);
      checkOutput("ext_ignored_evts", evtCount - evtBase, 64'd0);

      // 4) pause sequence swallowed, then 1
      evtBase = evtCount;
      applyStimulus(8'hE1);
      applyStimulus(8'h14);
      applyStimulus(8'h77);
      applyStimulus(8'hE1);
      applyStimulus(8'hF0);
      applyStimulus(8'h14);
      applyStimulus(8'hF0);
      applyStimulus(8'h77);
      applyStimulus(8'h16);
      checkOutput("pause_kb", kb_state, 64'h1);
      checkOutput("pause_evts", evtCount - evtBase, 64'd1);
      applyStimulus(8'hF0);
      applyStimulus(8'h16);
      checkOutput("pause_cleanup_kb", kb_state, 64'h0);

      // 5) timeout boundary: short wait keeps the break prefix, long wait drops it
      applyStimulus(8'hF0);
      idleCycles(TOUT / 2);
      applyStimulus(8'h1C);
      checkOutput("prefix_kept_kb", kb_state, 64'h0);
      applyStimulus(8'hF0);
      idleCycles(TOUT + 4);
      applyStimulus(8'h1C);
      checkOutput("timeout_make_kb", kb_state, 64'h400);
      checkOutput("timeout_make_evt", {key_evt, key_evt_make}, 64'h3);
      applyStimulus(8'h12);
      applyStimulus(8'h1A);
      checkOutput("shift_z_kb", kb_state, 64'h1_8400);
      evtBase = evtCount;
      applyStimulus(8'hAA);
      checkOutput("bat_clear_kb", kb_state, 64'h0);
      checkOutput("bat_clear_any", any_key, 64'h0);
      idleCycles(1);
      checkOutput("bat_clear_evts", evtCount - evtBase, 64'd0);

      // 6) column scan with A and N held
      applyStimulus(8'h1C);
      applyStimulus(8'h31);
      checkOutput("scan_kb", kb_state, 64'h80_0400);
      checkOutput("scan_idle_col", col_n, 64'h1F);
      row_sel = ~8'h04;
      idleCycles(1);
      checkOutput("scan_row2_col", col_n, 64'h1E);
      row_sel = ~8'h14;
      idleCycles(1);
      checkOutput("scan_row24_col", col_n, 64'h16);
      row_sel = ~8'h10;
      idleCycles(1);
      checkOutput("scan_row4_col", col_n, 64'h17);
      row_sel = 8'hFF;
      idleCycles(1);
      checkOutput("scan_none_col", col_n, 64'h1F);

      // back-to-back bytes: S and D on consecutive cycles
      @(negedge clk);
      data_valid = 1'b1;
      data       = 8'h1B;
      @(negedge clk);
      data       = 8'h23;
      @(negedge clk);
      data_valid = 1'b0;
      data       = 8'h00;
      checkOutput("burst_kb", kb_state, 64'h80_1C00);

      // reset in the middle of a break prefix
      applyStimulus(8'hAA);
      applyStimulus(8'hF0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_kb", kb_state, 64'h0);
      idleCycles(2);
      rst_n = 1'b1;
      idleCycles(1);
      applyStimulus(8'h1C);
      checkOutput("postreset_kb", kb_state, 64'h400);
      checkOutput("postreset_evt", {key_evt, key_evt_make, key_evt_idx}, {56'h0, 1'b1, 1'b1, 6'd10});

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
